// File: rtl/mor1kx_cfgrs_spr_port.sv
// mor1kx_cfgrs_spr_port: read-only configuration SPR port for group 0, with optional ack delay and a sticky write-error flag
module mor1kx_cfgrs_spr_port #(
  parameter int         OPTION_ACK_DELAY   = 0,
  parameter logic [7:0] OPTION_PIPELINE_ID = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spr_bus_stb_i,
  input  logic        spr_bus_we_i,
  input  logic [15:0] spr_bus_addr_i,
  input  logic [31:0] spr_bus_dat_i,
  input  logic [31:0] spr_vr,
  input  logic [31:0] spr_vr2,
  input  logic [31:0] spr_upr,
  input  logic [31:0] spr_cpucfgr,
  input  logic [31:0] spr_dmmucfgr,
  input  logic [31:0] spr_immucfgr,
  input  logic [31:0] spr_dccfgr,
  input  logic [31:0] spr_iccfgr,
  input  logic [31:0] spr_dcfgr,
  input  logic [31:0] spr_pccfgr,
  input  logic [31:0] spr_fpcsr,
  input  logic [31:0] spr_avr,
  output logic        spr_bus_ack_o,
  output logic [31:0] spr_bus_dat_o,
  output logic        spr_wr_err_o,
  input  logic        spr_wr_err_clr_i
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;
  localparam logic [1:0] DELAY = 2'(OPTION_ACK_DELAY);
  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [4:0]  idx;
  logic        we_q;
  logic        match;
  logic        start;
  logic [31:0] rd;
  logic        unused_dat;
  assign unused_dat = ^spr_bus_dat_i;
  // Only group 0, index 0..31 belongs to this block
  assign match = spr_bus_addr_i[15:5] == 11'd0;
  assign start = state == IDLE && spr_bus_stb_i && match;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? (DELAY != 2'd0 ? WAIT : ACK) : IDLE;
      WAIT:    state_nxt = !spr_bus_stb_i ? IDLE : cnt == 2'd1 ? ACK : WAIT;
      ACK:     state_nxt = spr_bus_stb_i ? HOLD : IDLE;
      HOLD:    state_nxt = spr_bus_stb_i ? HOLD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      idx          <= 5'd0;
      we_q         <= 1'b0;
      spr_wr_err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        idx  <= spr_bus_addr_i[4:0];
        we_q <= spr_bus_we_i;
        cnt  <= DELAY;
      end else if (state == WAIT) begin
        cnt <= cnt - 2'd1;
      end
      // A set on the ack cycle overrides a simultaneous clear
      spr_wr_err_o <= (spr_bus_ack_o && we_q) || (spr_wr_err_o && !spr_wr_err_clr_i);
    end
  end
  always_comb begin
    rd = 32'h0;
    case (idx)
      5'd0:    rd = spr_vr;
      5'd1:    rd = spr_upr;
      5'd2:    rd = spr_cpucfgr;
      5'd3:    rd = spr_dmmucfgr;
      5'd4:    rd = spr_immucfgr;
      5'd5:    rd = spr_dccfgr;
      5'd6:    rd = spr_iccfgr;
      5'd7:    rd = spr_dcfgr;
      5'd8:    rd = spr_pccfgr;
      5'd9:    rd = {spr_vr2[31:8], spr_vr2[7:0] | OPTION_PIPELINE_ID};
      5'd10:   rd = spr_avr;
      5'd20:   rd = spr_fpcsr;
      default: rd = 32'h0;
    endcase
  end
  assign spr_bus_ack_o = state == ACK;
  assign spr_bus_dat_o = spr_bus_ack_o && !we_q ? rd : 32'h0;
endmodule

// File: tb/tb_mor1kx_cfgrs_spr_port.sv
// tb_mor1kx_cfgrs_spr_port: three DUTs (ack delay 0, 2 with pipeline id 1, and 3) checked by vector table and scoreboard
module tb_mor1kx_cfgrs_spr_port;
  localparam logic [31:0] VR = 32'h1200_0001, VR2 = 32'h0105_0000, UPR = 32'h0000_0705;
  localparam logic [31:0] CPU = 32'h0000_0020, DMMU = 32'h0000_0011, IMMU = 32'h0000_0022;
  localparam logic [31:0] DC = 32'h0000_0033, IC = 32'h0000_0044, DCF = 32'h0000_0055;
  localparam logic [31:0] PCC = 32'h0000_0066, FPCSR = 32'h0000_0077, AVR = 32'h0102_0300;
  typedef struct { int k; logic [15:0] a; logic w; logic ack; logic [31:0] dat; } vec_t;
  typedef struct { int k; logic [31:0] dat; int lat; } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stb, we, clr, ack, err, err_m;
  logic [15:0] addr [3];
  logic [31:0] dat [3];
  int          checks = 0;
  int          errors = 0;
  vec_t        v[$];
  exp_t        sb[$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mor1kx_cfgrs_spr_port #(
      .OPTION_ACK_DELAY(g == 0 ? 0 : g + 1),
      .OPTION_PIPELINE_ID(g == 1 ? 8'h01 : 8'h00)
    ) dut (
      .clk(clk), .rst(rst),
      .spr_bus_stb_i(stb[g]), .spr_bus_we_i(we[g]), .spr_bus_addr_i(addr[g]),
      .spr_bus_dat_i(32'hDEAD_BEEF),
      .spr_vr(VR), .spr_vr2(VR2), .spr_upr(UPR), .spr_cpucfgr(CPU),
      .spr_dmmucfgr(DMMU), .spr_immucfgr(IMMU), .spr_dccfgr(DC), .spr_iccfgr(IC),
      .spr_dcfgr(DCF), .spr_pccfgr(PCC), .spr_fpcsr(FPCSR), .spr_avr(AVR),
      .spr_bus_ack_o(ack[g]), .spr_bus_dat_o(dat[g]),
      .spr_wr_err_o(err[g]), .spr_wr_err_clr_i(clr[g])
    );
  end
  function automatic int dly(input int k);
    return k == 0 ? 0 : k + 1;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // Drives one request, scrambles the address after capture, and keeps stb high for hold cycles after ack
  task automatic txn(input int k, input logic [15:0] a, input logic w, input logic exp_ack,
                     input logic [31:0] exp_dat, input int hold);
    int n;
    exp_t e;
    stb[k] = 1'b1;
    addr[k] = a;
    we[k] = w;
    if (exp_ack) sb.push_back('{k, exp_dat, 1 + dly(k)});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      addr[k] = ~a;
    end while (!ack[k] && n < 12);
    if (exp_ack) begin
      e = sb.pop_front();
      chk("ack_seen", {31'd0, ack[k]}, 32'd1);
      if (ack[k]) begin
        chk("latency", n, e.lat);
        chk("rd_data", dat[k], e.dat);
      end
      repeat (hold) begin
        @(negedge clk);
        chk("single_pulse", {31'd0, ack[k]}, 32'd0);
        chk("dat_idle", dat[k], 32'd0);
      end
    end else begin
      chk("no_ack", {31'd0, ack[k]}, 32'd0);
    end
    stb[k] = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    int n;
    rst = 1'b0;
    stb = '0;
    we = '0;
    clr = '0;
    err_m = '0;
    for (int k = 0; k < 3; k++) addr[k] = 16'h0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ack", {31'd0, ack[k]}, 32'd0);
      chk("reset_dat", dat[k], 32'd0);
      chk("reset_err", {31'd0, err[k]}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    v.push_back('{0, 16'h0001, 1'b0, 1'b1, UPR});
    v.push_back('{0, 16'h0000, 1'b0, 1'b1, VR});
    v.push_back('{0, 16'h0002, 1'b0, 1'b1, CPU});
    v.push_back('{0, 16'h0003, 1'b0, 1'b1, DMMU});
    v.push_back('{0, 16'h0004, 1'b0, 1'b1, IMMU});
    v.push_back('{0, 16'h0005, 1'b0, 1'b1, DC});
    v.push_back('{0, 16'h0006, 1'b0, 1'b1, IC});
    v.push_back('{0, 16'h0007, 1'b0, 1'b1, DCF});
    v.push_back('{0, 16'h0008, 1'b0, 1'b1, PCC});
    v.push_back('{0, 16'h0009, 1'b0, 1'b1, 32'h0105_0000});
    v.push_back('{0, 16'h000A, 1'b0, 1'b1, AVR});
    v.push_back('{0, 16'h0014, 1'b0, 1'b1, FPCSR});
    v.push_back('{0, 16'h000F, 1'b0, 1'b1, 32'h0});
    v.push_back('{0, 16'h001F, 1'b0, 1'b1, 32'h0});
    v.push_back('{0, 16'h0800, 1'b0, 1'b0, 32'h0});
    v.push_back('{0, 16'h0020, 1'b0, 1'b0, 32'h0});
    v.push_back('{1, 16'h0009, 1'b0, 1'b1, 32'h0105_0001});
    v.push_back('{1, 16'h0001, 1'b0, 1'b1, UPR});
    v.push_back('{2, 16'h000A, 1'b0, 1'b1, AVR});
    v.push_back('{0, 16'h0002, 1'b1, 1'b1, 32'h0});
    v.push_back('{1, 16'h0015, 1'b1, 1'b1, 32'h0});
    v.push_back('{2, 16'h0800, 1'b1, 1'b0, 32'h0});
    v.push_back('{1, 16'h0820, 1'b0, 1'b0, 32'h0});
    foreach (v[i]) begin
      txn(v[i].k, v[i].a, v[i].w, v[i].ack, v[i].dat, 2);
      if (v[i].ack && v[i].w) err_m[v[i].k] = 1'b1;
      chk("err_flag", {31'd0, err[v[i].k]}, {31'd0, err_m[v[i].k]});
    end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("clr_alone", {31'd0, err[0]}, 32'd0);
    // Write whose ack cycle coincides with a clear: the set must win
    stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0002;
    @(negedge clk);
    chk("wr_ack", {31'd0, ack[0]}, 32'd1);
    chk("wr_dat", dat[0], 32'd0);
    chk("err_before_set", {31'd0, err[0]}, 32'd0);
    clr[0] = 1'b1;
    @(negedge clk);
    chk("set_wins", {31'd0, err[0]}, 32'd1);
    clr[0] = 1'b0;
    stb[0] = 1'b0;
    we[0] = 1'b0;
    @(negedge clk);
    txn(0, 16'h0001, 1'b0, 1'b1, UPR, 0);
    txn(0, 16'h0000, 1'b0, 1'b1, VR, 2);
    // Delay 3: drop stb during the second WAIT cycle of a write
    stb[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0002;
    repeat (2) @(negedge clk);
    stb[2] = 1'b0;
    we[2] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_ack", {31'd0, ack[2]}, 32'd0);
    end
    chk("abort_no_err", {31'd0, err[2]}, 32'd0);
    txn(2, 16'h000A, 1'b0, 1'b1, AVR, 2);
    // Reset during WAIT on the delay-2 instance, stb kept high across it
    stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0001;
    @(negedge clk);
    chk("wait_no_ack", {31'd0, ack[1]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, ack[1]}, 32'd0);
    chk("rst_mid_dat", dat[1], 32'd0);
    chk("rst_mid_err0", {31'd0, err[0]}, 32'd0);
    chk("rst_mid_err1", {31'd0, err[1]}, 32'd0);
    rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[1] && n < 12);
    chk("restart_lat", n, 32'd3);
    chk("restart_dat", dat[1], UPR);
    stb[1] = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mor1kx_cfgrs_spr_port.md
MOR1KX_CFGRS_SPR_PORT -- requirements
Module: mor1kx_cfgrs_spr_port

Interface
REQ-001 SHALL have parameter OPTION_ACK_DELAY, default 0, giving extra wait cycles before ack; legal range 0..3.
REQ-002 SHALL have parameter OPTION_PIPELINE_ID, default 8'd0, which is ORed into VR2[7:0] on read.
REQ-003 SHALL have port clk  input  1  core clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port spr_bus_stb_i  input  1  access request; held until ack.
REQ-006 SHALL have port spr_bus_we_i  input  1  1 = mtspr, 0 = mfspr.
REQ-007 SHALL have port spr_bus_addr_i  input  16  SPR address as {group[15:11], index[10:0]}.
REQ-008 SHALL have port spr_bus_dat_i  input  32  write data; ignored.
REQ-009 SHALL have ports spr_vr, spr_vr2, spr_upr, spr_cpucfgr, spr_dmmucfgr, spr_immucfgr, spr_dccfgr, spr_iccfgr, spr_dcfgr, spr_pccfgr, spr_fpcsr, spr_avr  input  32 each  static configuration values.
REQ-010 SHALL have port spr_bus_ack_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port spr_bus_dat_o  output  32  read data, valid only while ack is high.
REQ-012 SHALL have port spr_wr_err_o  output  1  sticky flag: a write to a read-only config SPR occurred.
REQ-013 SHALL have port spr_wr_err_clr_i  input  1  clears spr_wr_err_o.

Function
REQ-014 SHALL decode only group 0 with index < 32; any other address does not match and the block stays silent (no ack).
REQ-015 SHALL map the following indices to the corresponding inputs: 0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR, 8 PCCFGR, 9 VR2 (with [7:0] ORed with OPTION_PIPELINE_ID), 10 AVR, 20 FPCSR.
REQ-016 SHALL return 32'h0 with a normal ack for any other matched index below 32.
REQ-017 SHALL implement the FSM states IDLE, WAIT, ACK and HOLD.
REQ-018 IDLE: when stb is high and the address matches, capture addr and we, load the wait counter with OPTION_ACK_DELAY, and go to WAIT if OPTION_ACK_DELAY > 0, else to ACK.
REQ-019 WAIT: decrement the 2-bit counter each cycle and go to ACK when the counter reaches 1 at the clock edge, giving exactly OPTION_ACK_DELAY WAIT cycles.
REQ-020 ACK: assert ack for exactly one cycle, drive the registered data, then go to HOLD.
REQ-021 HOLD: wait for stb to go low, then return to IDLE; a new request needs at least one cycle of stb low.
REQ-022 Read latency from the stb-sample edge to ack SHALL be 1 + OPTION_ACK_DELAY cycles.
REQ-023 Read data SHALL be sampled from the inputs on the cycle ack is asserted, using the captured address; spr_bus_dat_o SHALL be 0 whenever ack is low.
REQ-024 A write (captured we = 1) SHALL be acked on the normal timing with spr_bus_dat_o = 0, SHALL not change state, and SHALL set spr_wr_err_o on the ack cycle.
REQ-025 Writes to unmapped indices below 32 SHALL also set spr_wr_err_o.
REQ-026 Abort: if stb falls while in WAIT, go to IDLE with no ack and no error set.
REQ-027 If stb falls in the ACK cycle, the ack SHALL still complete and the FSM goes to IDLE instead of HOLD.
REQ-028 If spr_wr_err_clr_i and a set condition occur in the same cycle, set SHALL win.
REQ-029 Changes to the address while stb is held SHALL be ignored after capture.

Reset
REQ-030 When rst is low at a clock edge: FSM = IDLE, counter = 0, spr_bus_ack_o = 0, spr_bus_dat_o = 0, spr_wr_err_o = 0.
REQ-031 Reset asserted mid-transaction SHALL abort with no ack; if stb is still high after reset releases, the request SHALL be treated as new in IDLE.

Verification
REQ-032 Delay 0: read addr 16'h0001 with spr_upr = 32'h0000_0705 -> ack 1 cycle after the sample edge, dat 32'h0000_0705, single pulse, and no second ack while stb is held.
REQ-033 Delay 2, pipeline ID 8'h01: read addr 16'h0009 with spr_vr2 = 32'h0105_0000 -> ack on the 3rd cycle, dat 32'h0105_0001.
REQ-034 Write addr 16'h0002 -> ack with dat 0 and spr_wr_err_o = 1 from the next cycle; assert clr alone -> flag returns to 0; assert clr together with a new write ack -> flag stays 1.
REQ-035 Addresses 16'h0800 and 16'h0020 -> no ack within 10 cycles; addr 16'h000F -> ack with dat 0.
REQ-036 Delay 3: drop stb in the 2nd WAIT cycle -> no ack and FSM back in IDLE; a new read to 16'h000A -> spr_avr returned.
REQ-037 Reset low during WAIT -> ack stays 0 and all outputs are 0 on the next edge.
